lr_stack: RTL and testbench
===========================

Name: lr_stack

Overview:
- Parametrised return-address stack; successor to the single link register.
- Holds up to DEPTH return addresses. Call pushes, return pops, and a direct write overwrites the top entry.
- Sits beside the register file. The control unit drives push, pop and wr_en; lr_out feeds the PC mux and the register-read path.
- Adds occupancy tracking and sticky overflow/underflow error flags that the single-register version did not have.

Parameters:
WIDTH, 16, bit width of each stored address
DEPTH, 8, number of entries; must be at least 2; need not be a power of two

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
push  input  1  push lr_in as the new top (call)
pop  input  1  discard the top entry (return)
wr_en  input  1  overwrite the top entry with lr_in; count unchanged
lr_in  input  WIDTH  data for push or wr_en
clr_err  input  1  clear the sticky error flags
lr_out  output  WIDTH  current top entry; 0 when empty
count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky; set when a push is accepted while full
underflow  output  1  sticky; set when a pop occurs while empty

Behaviour:
- All outputs are registered or are decoded from registered state. An operation sampled at edge N is visible on outputs after edge N.
- Reset: rst=1 at posedge forces lr_out=0, count=0, empty=1, full=0, overflow=0, underflow=0.
  - rst overrides every other input in that cycle.
  - Storage array contents need not be cleared.
  - Mid-sequence reset discards all entries.
- Storage is a circular buffer with a top pointer that wraps modulo DEPTH.
- Command decode, in priority order:
  - push=1, pop=0:
    - Not full: top advances, entry := lr_in, count+1.
    - Full: top advances with wrap, overwriting the oldest entry; count stays DEPTH; overflow:=1.
  - push=0, pop=1:
    - Not empty: top retreats, count-1, lr_out shows the previous entry, or 0 if count becomes 0.
    - Empty: no state change except underflow:=1.
  - push=1, pop=1 (tail call):
    - Not empty: top entry := lr_in, count unchanged, no flags.
    - Empty: behaves as push, count becomes 1.
  - push=0, pop=0, wr_en=1:
    - Not empty: top entry := lr_in.
    - Empty: behaves as push, count becomes 1. This keeps plain link-register usage working.
  - wr_en is ignored whenever push or pop is 1.
  - No command: hold all state.
- Error flags:
  - clr_err=1 clears overflow and underflow.
  - If an error event occurs in the same cycle as clr_err, the set wins.
- Status decode:
  - lr_out is 0 whenever empty=1, regardless of stale array contents.
  - empty and full are never both 1.
- Arithmetic:
  - Pointer arithmetic wraps explicitly at DEPTH-1 ↔ 0; no reliance on power-of-two truncation.
  - count saturates at 0 and DEPTH and never wraps.

Test Plan:
1. Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles → count=3, lr_out=0x3333; pop → lr_out=0x2222, count=2; pop twice → lr_out=0, empty=1.
2. Push 0x0001..0x0009 on 9 consecutive cycles → after the 8th push full=1; after the 9th, count=8, overflow=1, lr_out=0x0009. Then 8 pops return 0x0008..0x0002 on lr_out in turn and end with empty=1; oldest entry 0x0001 is lost.
3. From empty, pop → underflow=1, count=0, lr_out=0. Next cycle clr_err=1 together with pop → underflow stays 1. Then clr_err alone → underflow=0.
4. From empty, wr_en=1 with lr_in=0xBEEF → count=1, lr_out=0xBEEF. wr_en=1 with 0xCAFE → count=1, lr_out=0xCAFE. push=1, pop=1, wr_en=1 with 0x1234 → count=1, lr_out=0x1234.
5. Push 0xAAAA, 0xBBBB, then rst=1 on the same cycle as push=1 → next cycle count=0, lr_out=0, flags 0. Push 0x5555 → count=1, lr_out=0x5555; no stale data appears after a pop (lr_out=0).
6. Random push/pop/wr_en/clr_err sequence of at least 10k cycles against a bounded queue model → lr_out, count, empty, full and flags match every cycle. Run for DEPTH=8 and DEPTH=5 (non-power-of-two wrap).

Source files
------------

// File: rtl/lr_stack.sv
// Return-address stack: circular buffer with a wrapping top pointer.
// It tracks occupancy and keeps sticky overflow/underflow flags.
module lr_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           lr_in,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           lr_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_lr_out;
    logic             r_overflow;
    logic             r_underflow;

    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_write;
    logic             w_do_pop;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    assign w_empty = (r_count == {CW{1'b0}});
    assign w_full  = (r_count == C_DEPTH);

    // Top pointer neighbours, wrapping explicitly so any DEPTH works
    always_comb begin
        if (r_top == P_LAST) begin
            w_top_inc = {PW{1'b0}};
        end else begin
            w_top_inc = r_top + PW'(1'b1);
        end
        if (r_top == {PW{1'b0}}) begin
            w_top_dec = P_LAST;
        end else begin
            w_top_dec = r_top - PW'(1'b1);
        end
    end

    // Command decode; an empty stack turns tail-call and write into a push
    always_comb begin
        w_do_push  = 1'b0;
        w_do_write = 1'b0;
        w_do_pop   = 1'b0;
        w_ovf_evt  = 1'b0;
        w_unf_evt  = 1'b0;
        case ({push, pop})
            2'b10: begin
                w_do_push = 1'b1;
                w_ovf_evt = w_full;
            end
            2'b01: begin
                if (w_empty) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_do_pop = 1'b1;
                end
            end
            2'b11: begin
                if (w_empty) begin
                    w_do_push = 1'b1;
                end else begin
                    w_do_write = 1'b1;
                end
            end
            2'b00: begin
                if (wr_en && w_empty) begin
                    w_do_push = 1'b1;
                end else if (wr_en) begin
                    w_do_write = 1'b1;
                end else begin
                    w_do_push = 1'b0;
                end
            end
            default: begin
                w_do_push = 1'b0;
            end
        endcase
    end

    // Storage array; deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[w_top_inc] <= lr_in;
        end else if (!rst && w_do_write) begin
            r_mem[r_top] <= lr_in;
        end
    end

    // Pointer, occupancy, registered top value and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top       <= {PW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_lr_out    <= {WIDTH{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_top    <= w_top_inc;
                r_lr_out <= lr_in;
                if (!w_full) begin
                    r_count <= r_count + CW'(1'b1);
                end
            end else if (w_do_write) begin
                r_lr_out <= lr_in;
            end else if (w_do_pop) begin
                r_top   <= w_top_dec;
                r_count <= r_count - CW'(1'b1);
                // Popping the last entry must show 0, not stale storage
                if (r_count == CW'(1'b1)) begin
                    r_lr_out <= {WIDTH{1'b0}};
                end else begin
                    r_lr_out <= r_mem[w_top_dec];
                end
            end
            r_overflow  <= w_ovf_evt | (r_overflow & ~clr_err);
            r_underflow <= w_unf_evt | (r_underflow & ~clr_err);
        end
    end

    assign lr_out    = r_lr_out;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_lr_stack.sv
// Bench for lr_stack: directed vector table plus a queue-model random run,
// applied to a DEPTH=8 and a DEPTH=5 instance.
module tb_lr_stack;

    typedef struct {
        logic [15:0] out;
        int          cnt;
        logic        emp;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    typedef struct {
        string       name;
        logic        r;
        logic        p;
        logic        o;
        logic        w;
        logic        c;
        logic [15:0] d;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic        clr_err;
    logic [15:0] lr_in;

    logic [15:0] o8;
    logic [3:0]  c8;
    logic        e8, f8, ov8, un8;
    logic [15:0] o5;
    logic [2:0]  c5;
    logic        e5, f5, ov5, un5;

    int          n_checks = 0;
    int          n_errors = 0;
    int          sel = 0;
    int          m_depth = 8;
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_unf;
    exp_t        exp_q[$];
    vec_t        tbl[$];

    lr_stack #(.WIDTH(16), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .wr_en(wr_en),
        .lr_in(lr_in), .clr_err(clr_err), .lr_out(o8), .count(c8),
        .empty(e8), .full(f8), .overflow(ov8), .underflow(un8)
    );

    lr_stack #(.WIDTH(16), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .wr_en(wr_en),
        .lr_in(lr_in), .clr_err(clr_err), .lr_out(o5), .count(c5),
        .empty(e5), .full(f5), .overflow(ov5), .underflow(un5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mke(logic [15:0] out, int cnt, logic emp, logic full,
                                 logic ovf, logic unf);
        exp_t e;
        e.out = out; e.cnt = cnt; e.emp = emp; e.full = full; e.ovf = ovf; e.unf = unf;
        return e;
    endfunction

    function automatic vec_t mk(string n, logic r, logic p, logic o, logic w, logic c,
                                logic [15:0] d, exp_t e);
        vec_t v;
        v.name = n; v.r = r; v.p = p; v.o = o; v.w = w; v.c = c; v.d = d; v.e = e;
        return v;
    endfunction

    task automatic check_cycle(input string name);
        exp_t        e;
        logic [15:0] ao;
        int          ac;
        logic        ae, af, aov, aun;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        if (sel == 0) begin
            ao = o8; ac = int'(c8); ae = e8; af = f8; aov = ov8; aun = un8;
        end else begin
            ao = o5; ac = int'(c5); ae = e5; af = f5; aov = ov5; aun = un5;
        end
        if (ao !== e.out || ac != e.cnt || ae !== e.emp || af !== e.full ||
            aov !== e.ovf || aun !== e.unf) begin
            n_errors++;
            $display("FAIL %s t=%0t got out=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b want out=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b",
                     name, $time, ao, ac, ae, af, aov, aun,
                     e.out, e.cnt, e.emp, e.full, e.ovf, e.unf);
        end
    endtask

    task automatic step(input string name, input logic r, input logic p, input logic o,
                        input logic w, input logic c, input logic [15:0] d, input exp_t e);
        @(negedge clk);
        rst = r; push = p; pop = o; wr_en = w; clr_err = c; lr_in = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_cycle(name);
    endtask

    // Reference model: a bounded queue, back = top of stack
    task automatic model(input logic r, input logic p, input logic o, input logic w,
                         input logic c, input logic [15:0] d, output exp_t e);
        logic ovf_e, unf_e;
        ovf_e = 1'b0;
        unf_e = 1'b0;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && !o) begin
                if (mq.size() == m_depth) begin
                    void'(mq.pop_front());
                    ovf_e = 1'b1;
                end
                mq.push_back(d);
            end else if (o && !p) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else unf_e = 1'b1;
            end else if ((p && o) || w) begin
                if (mq.size() == 0) mq.push_back(d);
                else mq[mq.size()-1] = d;
            end
            m_ovf = ovf_e | (m_ovf & ~c);
            m_unf = unf_e | (m_unf & ~c);
        end
        e = mke((mq.size() > 0) ? mq[mq.size()-1] : 16'h0000, mq.size(),
                mq.size() == 0, mq.size() == m_depth, m_ovf, m_unf);
    endtask

    task automatic rand_phase(input string name, input int ncyc);
        exp_t        e;
        logic        r, p, o, w, c;
        logic [15:0] d;
        model(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, e);
        step({name, "_rst"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, e);
        for (int i = 0; i < ncyc; i++) begin
            r = ($urandom_range(0, 499) == 0);
            p = ($urandom_range(0, 99) < 45);
            o = ($urandom_range(0, 99) < 45);
            w = ($urandom_range(0, 99) < 30);
            c = ($urandom_range(0, 15) == 0);
            d = 16'($urandom);
            model(r, p, o, w, c, d, e);
            step(name, r, p, o, w, c, d, e);
        end
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; wr_en = 1'b0; clr_err = 1'b0; lr_in = 16'h0000;
        m_ovf = 1'b0; m_unf = 1'b0;

        // name, rst, push, pop, wr_en, clr_err, lr_in, expected {out,cnt,emp,full,ovf,unf}
        tbl.push_back(mk("reset",     1,0,0,0,0, 16'h0000, mke(16'h0000,0,1,0,0,0)));
        tbl.push_back(mk("push1",     0,1,0,0,0, 16'h1111, mke(16'h1111,1,0,0,0,0)));
        tbl.push_back(mk("push2",     0,1,0,0,0, 16'h2222, mke(16'h2222,2,0,0,0,0)));
        tbl.push_back(mk("push3",     0,1,0,0,0, 16'h3333, mke(16'h3333,3,0,0,0,0)));
        tbl.push_back(mk("pop1",      0,0,1,0,0, 16'h0000, mke(16'h2222,2,0,0,0,0)));
        tbl.push_back(mk("pop2",      0,0,1,0,0, 16'h0000, mke(16'h1111,1,0,0,0,0)));
        tbl.push_back(mk("pop3",      0,0,1,0,0, 16'h0000, mke(16'h0000,0,1,0,0,0)));
        tbl.push_back(mk("unf_pop",   0,0,1,0,0, 16'h0000, mke(16'h0000,0,1,0,0,1)));
        tbl.push_back(mk("unf_setwin",0,0,1,0,1, 16'h0000, mke(16'h0000,0,1,0,0,1)));
        tbl.push_back(mk("unf_clr",   0,0,0,0,1, 16'h0000, mke(16'h0000,0,1,0,0,0)));
        tbl.push_back(mk("wr_empty",  0,0,0,1,0, 16'hBEEF, mke(16'hBEEF,1,0,0,0,0)));
        tbl.push_back(mk("wr_top",    0,0,0,1,0, 16'hCAFE, mke(16'hCAFE,1,0,0,0,0)));
        tbl.push_back(mk("tail_wr",   0,1,1,1,0, 16'h1234, mke(16'h1234,1,0,0,0,0)));
        tbl.push_back(mk("pop_tail",  0,0,1,0,0, 16'h0000, mke(16'h0000,0,1,0,0,0)));
        tbl.push_back(mk("tail_empty",0,1,1,0,0, 16'hABCD, mke(16'hABCD,1,0,0,0,0)));
        tbl.push_back(mk("push_t2",   0,1,0,0,0, 16'h0002, mke(16'h0002,2,0,0,0,0)));
        tbl.push_back(mk("tail_top",  0,1,1,0,0, 16'h0009, mke(16'h0009,2,0,0,0,0)));
        tbl.push_back(mk("pop_t1",    0,0,1,0,0, 16'h0000, mke(16'hABCD,1,0,0,0,0)));
        tbl.push_back(mk("pop_t0",    0,0,1,0,0, 16'h0000, mke(16'h0000,0,1,0,0,0)));
        tbl.push_back(mk("pushA",     0,1,0,0,0, 16'hAAAA, mke(16'hAAAA,1,0,0,0,0)));
        tbl.push_back(mk("pushB",     0,1,0,0,0, 16'hBBBB, mke(16'hBBBB,2,0,0,0,0)));
        tbl.push_back(mk("rst_push",  1,1,0,0,0, 16'h7777, mke(16'h0000,0,1,0,0,0)));
        tbl.push_back(mk("push5",     0,1,0,0,0, 16'h5555, mke(16'h5555,1,0,0,0,0)));
        tbl.push_back(mk("no_stale",  0,0,1,0,0, 16'h0000, mke(16'h0000,0,1,0,0,0)));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].name, tbl[i].r, tbl[i].p, tbl[i].o, tbl[i].w, tbl[i].c,
                 tbl[i].d, tbl[i].e);
        end

        // Fill past full on DEPTH=8: the ninth push overwrites the oldest entry
        for (int i = 1; i <= 9; i++) begin
            step("ovf_push", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(i),
                 mke(16'(i), (i > 8) ? 8 : i, 1'b0, i >= 8, i == 9, 1'b0));
        end
        for (int k = 1; k <= 8; k++) begin
            step("ovf_pop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,
                 mke((k < 8) ? 16'(9 - k) : 16'h0000, 8 - k, k == 8, 1'b0, 1'b1, 1'b0));
        end
        step("ovf_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000,
             mke(16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0));

        sel = 0;
        m_depth = 8;
        rand_phase("rand8", 10000);
        sel = 1;
        m_depth = 5;
        rand_phase("rand5", 10000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
